fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the single-cycle control decoder. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. It presents the fetched instruction, with its opcode field `instr[31:21]` split out for the decoder. On each `advance` it moves the PC to PC+4 or to a branch target, using the control and ALU-zero outputs of the current instruction.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/next_pc_calc.sv | 35 +++
 rtl/fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// No logic of its own; imported by fetch_unit and next_pc_calc.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam int          PC_INCR    = 4;
    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 21;
    localparam logic [31:0] HALT_WORD  = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC select: sequential PC+4 or PC-relative branch target (offset in words).
// Latency: combinational; backpressure: none, pure function of its inputs.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic              branch,
    input  logic              uncond_branch,
    input  logic              zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic take;

    // Unconditional wins outright so an unknown conditional flag cannot leak into the select.
    always_comb begin
        take = 1'b0;
        if (uncond_branch) begin
            take = 1'b1;
        end else begin
            take = branch & zero;
        end
    end

    always_comb begin
        next_pc = pc + ADDR_W'(PC_INCR);
        if (take) begin
            next_pc = pc + (branch_offset << 2);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches over imem req/ack, holds the instruction until advance.
// Latency >= 2 cycles/instr; waits on imem_ack and advance. FETCH_RETIRE_COUNT_EN adds a retired counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic               CLK,
    input  logic               resetl,
    input  logic [ADDR_W-1:0]  startpc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [10:0]        opcode,
    output logic [ADDR_W-1:0]  pc,
    input  logic               branch,
    input  logic               uncond_branch,
    input  logic               zero,
    input  logic [ADDR_W-1:0]  branch_offset,
    input  logic               advance
`ifdef FETCH_RETIRE_COUNT_EN
    ,
    output logic [31:0]        retired
`endif
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  next_pc;
    logic               fetch_done;
    logic               commit;

    assign fetch_done = (state_q == ST_REQ) && imem_ack;
    assign commit     = (state_q == ST_ISSUE) && advance;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc            (pc_q),
        .branch_offset (branch_offset),
        .branch        (branch),
        .uncond_branch (uncond_branch),
        .zero          (zero),
        .next_pc       (next_pc)
    );

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack) begin
                    state_d = (imem_rdata == INSTR_W'(HALT_WORD)) ? ST_HALT : ST_ISSUE;
                end
            end
            ST_ISSUE: if (advance) state_d = ST_REQ;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_BOOT;
        endcase
    end

    // Request/valid decode straight from state so reset drops them without a clock edge.
    always_comb begin
        imem_req    = (state_q == ST_REQ);
        instr_valid = (state_q == ST_ISSUE);
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (state_q == ST_BOOT) pc_d = startpc;
        if (commit)             pc_d = next_pc;
        if (fetch_done)         instr_d = imem_rdata;
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign opcode    = instr_q[OPCODE_MSB:OPCODE_LSB];

`ifdef FETCH_RETIRE_COUNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (commit) retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`endif

endmodule
